// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg -- shared definitions for the multi-cycle control unit.
//   state_e  : FSM state encoding, also visible on the debug state port
//   kind_e   : instruction class remembered from EXEC for MEM/WB
//   OP_*     : RV32 base opcodes the controller accepts
//   ALU_*    : alu_ctrl encodings, shared by mc_alu_dec and mc_ctrl
//   RES_*    : result_src encodings selected in WB
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      K_ALU   = 2'd0,
      K_LOAD  = 2'd1,
      K_STORE = 2'd2,
      K_JAL   = 2'd3
   } kind_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_SLL = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   function automatic logic is_legal_op(input logic [6:0] op);
      return (op == OP_R) || (op == OP_IALU) || (op == OP_LOAD) ||
             (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JAL) ||
             (op == OP_LUI);
   endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec -- combinational funct decode for the control unit.
//   opcode   in  : instr[6:0]
//   funct3   in  : instr[14:12]
//   funct7b5 in  : instr[30]
//   alu_ctrl out : ALU operation (ALU_* encodings)
//   bad      out : funct combination (or opcode) the datapath cannot execute
module mc_alu_dec
   import mc_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output logic [2:0] alu_ctrl,
   output logic       bad
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      bad      = 1'b0;
      case (opcode)
         OP_R: begin
            case ({funct7b5, funct3})
               4'b0_000: alu_ctrl = ALU_ADD;
               4'b1_000: alu_ctrl = ALU_SUB;
               4'b0_111: alu_ctrl = ALU_AND;
               4'b0_110: alu_ctrl = ALU_OR;
               4'b0_100: alu_ctrl = ALU_XOR;
               4'b0_010: alu_ctrl = ALU_SLT;
               4'b0_001: alu_ctrl = ALU_SLL;
               4'b0_101: alu_ctrl = ALU_SRL;
               default:  bad      = 1'b1;
            endcase
         end
         OP_IALU: begin
            // funct7b5 is immediate data except for shifts, where it selects
            // the arithmetic variants that the ALU does not implement.
            case (funct3)
               3'b000: alu_ctrl = ALU_ADD;
               3'b111: alu_ctrl = ALU_AND;
               3'b110: alu_ctrl = ALU_OR;
               3'b100: alu_ctrl = ALU_XOR;
               3'b010: alu_ctrl = ALU_SLT;
               3'b001: begin
                  alu_ctrl = ALU_SLL;
                  bad      = funct7b5;
               end
               3'b101: begin
                  alu_ctrl = ALU_SRL;
                  bad      = funct7b5;
               end
               default: bad = 1'b1;
            endcase
         end
         OP_BRANCH: begin
            // Only beq/bne are supported; compare is done by subtraction.
            alu_ctrl = ALU_SUB;
            bad      = (funct3[2:1] != 2'b00);
         end
         OP_LOAD, OP_STORE, OP_LUI, OP_JAL: alu_ctrl = ALU_ADD;
         default: bad = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl -- multi-cycle RV32 subset control FSM
// (FETCH -> DECODE -> EXEC -> [MEM] -> [WB], absorbing TRAP).
//   clk, rst_n      : clock, asynchronous active-low reset
//   instr           : instruction register, looked at in DECODE and EXEC
//   zero            : ALU zero flag for beq/bne in EXEC
//   mem_ready       : memory access completes this cycle
//   pc_en, ir_en, ALUsrc, alu_ctrl, reg_write, mem_read, mem_write,
//   result_src, pc_src : datapath controls
//   illegal         : high while in TRAP
//   state           : debug view of the FSM state
//   retired         : completed-instruction counter, only present when the
//                     macro MC_CTRL_PERF_EN is defined
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_en,
   output logic        ir_en,
   output logic        ALUsrc,
   output logic [2:0]  alu_ctrl,
   output logic        reg_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic [1:0]  result_src,
   output logic        pc_src,
   output logic        illegal,
   output logic [2:0]  state
`ifdef MC_CTRL_PERF_EN
   ,
   output logic [DATA_WIDTH-1:0] retired
`endif
);

   state_e     state_q, state_d;
   kind_e      kind_q, kind_d;
   logic       retire;
   logic [6:0] opcode;
   logic [2:0] dec_alu;
   logic       dec_bad;
   logic       unused_bits;

   assign opcode = instr[6:0];
   assign state  = state_q;

   mc_alu_dec u_alu_dec (
      .opcode   (opcode),
      .funct3   (instr[14:12]),
      .funct7b5 (instr[30]),
      .alu_ctrl (dec_alu),
      .bad      (dec_bad)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         kind_q  <= K_ALU;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      kind_d     = kind_q;
      retire     = 1'b0;
      pc_en      = 1'b0;
      ir_en      = 1'b0;
      ALUsrc     = 1'b0;
      alu_ctrl   = ALU_ADD;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      result_src = RES_ALU;
      pc_src     = 1'b0;
      illegal    = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_en   = 1'b1;
               pc_en   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            state_d = is_legal_op(opcode) ? S_EXEC : S_TRAP;
         end
         S_EXEC: begin
            // An unsupported funct leaves every control low on the way to TRAP.
            if (dec_bad) begin
               state_d = S_TRAP;
            end else begin
               alu_ctrl = dec_alu;
               case (opcode)
                  OP_R: begin
                     kind_d  = K_ALU;
                     state_d = S_WB;
                  end
                  OP_IALU, OP_LUI: begin
                     ALUsrc  = 1'b1;
                     kind_d  = K_ALU;
                     state_d = S_WB;
                  end
                  OP_LOAD: begin
                     ALUsrc  = 1'b1;
                     kind_d  = K_LOAD;
                     state_d = S_MEM;
                  end
                  OP_STORE: begin
                     ALUsrc  = 1'b1;
                     kind_d  = K_STORE;
                     state_d = S_MEM;
                  end
                  OP_BRANCH: begin
                     // funct3[0] separates bne from beq.
                     pc_en   = instr[12] ? !zero : zero;
                     pc_src  = pc_en;
                     retire  = 1'b1;
                     state_d = S_FETCH;
                  end
                  OP_JAL: begin
                     pc_en   = 1'b1;
                     pc_src  = 1'b1;
                     kind_d  = K_JAL;
                     state_d = S_WB;
                  end
                  default: state_d = S_TRAP;
               endcase
            end
         end
         S_MEM: begin
            if (kind_q == K_LOAD) mem_read  = 1'b1;
            else                  mem_write = 1'b1;
            if (mem_ready) begin
               retire  = (kind_q != K_LOAD);
               state_d = (kind_q == K_LOAD) ? S_WB : S_FETCH;
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            case (kind_q)
               K_LOAD:  result_src = RES_MEM;
               K_JAL:   result_src = RES_PC4;
               default: result_src = RES_ALU;
            endcase
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_TRAP: begin
            illegal = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase

      // Outputs drop the moment reset asserts, not at the next edge.
      if (!rst_n) begin
         pc_en      = 1'b0;
         ir_en      = 1'b0;
         ALUsrc     = 1'b0;
         alu_ctrl   = ALU_ADD;
         reg_write  = 1'b0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         result_src = RES_ALU;
         pc_src     = 1'b0;
         illegal    = 1'b0;
      end
   end

`ifdef MC_CTRL_PERF_EN
   logic [DATA_WIDTH-1:0] retired_q, retired_d;

   always_comb begin
      retired_d = retired_q;
      if (retire) retired_d = retired_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) retired_q <= '0;
      else        retired_q <= retired_d;
   end

   assign retired     = retired_q;
   // Instruction fields irrelevant to control decode.
   assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};
`else
   // Instruction fields irrelevant to control decode; the retire strobe and
   // width parameter only matter when the counter is built.
   assign unused_bits = ^{instr[31], instr[29:15], instr[11:7], retire, DATA_WIDTH[0]};
`endif

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the datapath operand width; it only sizes the perf counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port instr  input  32  the instruction register contents, sampled in DECODE and EXEC.
REQ-005 SHALL have port zero  input  1  the ALU zero flag, used in EXEC for branches.
REQ-006 SHALL have port mem_ready  input  1  the memory handshake; 1 means the access completes this cycle.
REQ-007 SHALL have outputs: pc_en 1, ir_en 1, ALUsrc 1, alu_ctrl 3, reg_write 1, mem_read 1, mem_write 1, result_src 2, pc_src 1, illegal 1, state 3 (debug).

Function
REQ-008 SHALL be a Moore/Mealy FSM with states FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-009 In FETCH, SHALL assert mem_read; on mem_ready=1, SHALL assert ir_en and pc_en with pc_src=0 (PC+4) and go to DECODE; otherwise it SHALL hold with ir_en=pc_en=0.
REQ-010 In DECODE, SHALL go to EXEC for opcodes 0110011 (R), 0010011 (I-ALU), 0000011 (load), 0100011 (store), 1100011 (branch), 1101111 (jal) and 0110111 (lui); for any other opcode it SHALL go to TRAP.
REQ-011 In EXEC, SHALL drive ALUsrc=0 for R and branch, and ALUsrc=1 for I-ALU, load, store and lui.
REQ-012 In EXEC, SHALL set alu_ctrl from funct3/funct7[5]: ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101, SLL 110, SRL 111; load, store, lui and jal force ADD, and branch forces SUB.
REQ-013 For an R-type or I-ALU funct3/funct7 combination outside the REQ-012 set, EXEC SHALL go to TRAP without asserting any write.
REQ-014 After EXEC: R, I-ALU, lui and jal SHALL go to WB; load and store SHALL go to MEM; branch SHALL go to FETCH.
REQ-015 For a branch in EXEC, SHALL assert pc_en=1 and pc_src=1 only when taken: funct3 000 (beq) with zero=1, or funct3 001 (bne) with zero=0; other branch funct3 values SHALL go to TRAP.
REQ-016 For jal in EXEC, SHALL assert pc_en=1 and pc_src=1 unconditionally.
REQ-017 In MEM, SHALL assert mem_read for a load or mem_write for a store and hold until mem_ready=1; a load then goes to WB and a store to FETCH.
REQ-018 mem_write SHALL be high for exactly the cycles spent in MEM for a store, and SHALL never be high in any other state.
REQ-019 In WB, SHALL assert reg_write=1 for exactly one cycle with result_src = 00 ALU, 01 memory or 10 PC+4 (jal), then go to FETCH.
REQ-020 Latencies with mem_ready held at 1 SHALL be: branch 3 cycles; R, I-ALU, lui, jal and store 4 cycles; load 5 cycles.
REQ-021 TRAP SHALL be absorbing: illegal=1, every enable and write output 0; only reset leaves it.
REQ-022 In any state, an output not named for that state SHALL be 0 (alu_ctrl 000, result_src 00).

Reset
REQ-023 rst_n=0 SHALL immediately force state FETCH, illegal=0 and all outputs 0, independent of clk and even in the middle of MEM.
REQ-024 On the first clk edge after rst_n deasserts, the FSM SHALL evaluate FETCH normally.

Configuration
REQ-025 With macro MC_CTRL_PERF_EN defined, the block SHALL add output retired [DATA_WIDTH-1:0], cleared by reset, incremented once per completed instruction, and wrapping from all-ones to 0.
REQ-026 A completed instruction SHALL be the WB exit, the MEM exit of a store, or the EXEC exit of a branch.
REQ-027 Without MC_CTRL_PERF_EN, the retired port and its counter SHALL not exist.

Structure
REQ-028 Package mc_ctrl_pkg SHALL hold the state enum, the opcode constants, the alu_ctrl encodings and the result_src encodings; the ALU decoder SHALL share the alu_ctrl encodings from it.
REQ-029 The combinational funct decode SHALL be a sub-module named mc_alu_dec, with inputs opcode, funct3 and funct7b5 and outputs alu_ctrl and a bad flag.

Verification
REQ-030 add x1,x2,x3 (0x003100B3) with mem_ready=1 -> states F,D,E,W; ALUsrc=0 and alu_ctrl=000 in E; reg_write=1 only in W.
REQ-031 lw with mem_ready low for 2 cycles in MEM -> MEM held 3 cycles with mem_read=1; WB has result_src=01; 7 cycles in total.
REQ-032 beq with zero=1 -> pc_en=1 and pc_src=1 in EXEC; with zero=0 -> pc_en=0; both return to FETCH after 3 cycles.
REQ-033 opcode 0x7F -> TRAP after DECODE and illegal=1 persists for 10 cycles; rst_n pulse -> FETCH and illegal=0.
REQ-034 sw, with rst_n asserted low mid-MEM -> mem_write drops to 0 in the same cycle without any clock edge, and state=FETCH.
REQ-035 With MC_CTRL_PERF_EN, sequence add, lw, sw, beq -> retired=4; with the counter preloaded to all-ones, one more instruction -> retired=0.
